port_io_ctrl: RTL and testbench

- Controller for the yg2019p processor's I/O port bus.
- Decodes port_id/write_strobe and queues output-port writes into a small FIFO.
- Drains the FIFO to the 7-segment display path with a valid/ready handshake and a minimum dwell per value.
- Returns the synchronized switches and a status byte on the processor's in_data bus.
- Sits between the processor core and bcd_display; replaces ad-hoc port decode in top-level modules.

---
 rtl/port_io_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/port_io_ctrl.sv | 161 ++++++++++++++++
 tb/tb_port_io_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/port_io_pkg.sv
// port_io_pkg
// Definitions shared by the yg2019p I/O port controller:
//   - default port addresses for the output, switch and status ports
//   - drain FSM state encoding
//   - bit positions of the flags inside the status byte
package port_io_pkg;

  localparam logic [7:0] DEFAULT_OUT_PORT  = 8'h03;
  localparam logic [7:0] DEFAULT_IN_PORT   = 8'h01;
  localparam logic [7:0] DEFAULT_STAT_PORT = 8'h02;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLD    = 2'd2
  } drain_state_t;

  localparam int STAT_OVF   = 7;
  localparam int STAT_FULL  = 6;
  localparam int STAT_EMPTY = 5;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO. A push while full is still accepted when a pop
// happens in the same cycle, so the count stays the same.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wr_data   write request and data
//   push_ok         the push in this cycle is accepted
//   pop             read request (ignored while empty)
//   rd_data         head entry (valid while !empty)
//   full, empty     occupancy flags
//   count           number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  output logic             push_ok,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem[rd_ptr];

  // Pointers and occupancy. DEPTH is a power of two, so the pointers
  // wrap modulo DEPTH simply by overflowing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; empty entries are never read out.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/port_io_ctrl.sv
// port_io_ctrl
// I/O port controller for the yg2019p processor. Decodes port writes,
// queues output-port data in a FIFO and drains it to the display with a
// valid/ready handshake and a minimum dwell, and returns the synchronized
// switches or a status byte on the read bus.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   port_id, write_strobe processor port address and write qualifier
//   out_data              processor write data
//   in_data               registered read data to the processor
//   sw                    asynchronous slide switches
//   disp_data, disp_valid value to the display and its valid flag
//   disp_ready            display accepts disp_data
//   overflow              sticky flag: a push was dropped
module port_io_ctrl
  import port_io_pkg::*;
#(
  parameter logic [7:0]  OUT_PORT    = DEFAULT_OUT_PORT,
  parameter logic [7:0]  IN_PORT     = DEFAULT_IN_PORT,
  parameter logic [7:0]  STAT_PORT   = DEFAULT_STAT_PORT,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] HOLD_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic [7:0] out_data,
  output logic [7:0] in_data,
  input  logic [7:0] sw,
  output logic [7:0] disp_data,
  output logic       disp_valid,
  input  logic       disp_ready,
  output logic       overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       sw_meta;
  logic [7:0]       sw_s;
  logic             push_req;
  logic             push_ok;
  logic             ovf_clear;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       fifo_head;
  logic [7:0]       status;

  drain_state_t     state, state_n;
  logic [7:0]       disp_data_n;
  logic             disp_valid_n;
  logic [15:0]      hold_cnt, hold_cnt_n;

  assign push_req  = write_strobe && (port_id == OUT_PORT);
  assign ovf_clear = write_strobe && (port_id == STAT_PORT) && out_data[7];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_req),
    .wr_data (out_data),
    .push_ok (push_ok),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Two-flop synchronizer for the asynchronous switches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_s    <= '0;
    end else begin
      sw_meta <= sw;
      sw_s    <= sw_meta;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    overflow <= 1'b0;
    else if (push_req && !push_ok) overflow <= 1'b1;
    else if (ovf_clear)            overflow <= 1'b0;
  end

  always_comb begin
    status             = '0;
    status[STAT_OVF]   = overflow;
    status[STAT_FULL]  = fifo_full;
    status[STAT_EMPTY] = fifo_empty;
    status[4:0]        = 5'(fifo_count);
  end

  // Read data is refreshed every cycle; the processor holds port_id long
  // enough that the registered value is settled when it samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    in_data <= '0;
    else if (port_id == IN_PORT)   in_data <= sw_s;
    else if (port_id == STAT_PORT) in_data <= status;
    else                           in_data <= '0;
  end

  // Drain FSM state and display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      state      <= state_n;
      disp_data  <= disp_data_n;
      disp_valid <= disp_valid_n;
      hold_cnt   <= hold_cnt_n;
    end
  end

  // Load a value in IDLE, wait for the display to take it in PRESENT,
  // then dwell HOLD_CYCLES clocks before the next value may be loaded.
  always_comb begin
    state_n      = state;
    disp_data_n  = disp_data;
    disp_valid_n = disp_valid;
    hold_cnt_n   = hold_cnt;
    fifo_pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          disp_data_n  = fifo_head;
          disp_valid_n = 1'b1;
          fifo_pop     = 1'b1;
          state_n      = PRESENT;
        end
      end
      PRESENT: begin
        if (disp_ready) begin
          disp_valid_n = 1'b0;
          if (HOLD_CYCLES == 16'd0) begin
            state_n = IDLE;
          end else begin
            hold_cnt_n = HOLD_CYCLES - 16'd1;
            state_n    = HOLD;
          end
        end
      end
      HOLD: begin
        if (hold_cnt == 16'd0) state_n = IDLE;
        else                   hold_cnt_n = hold_cnt - 16'd1;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_port_io_ctrl.sv
// tb_port_io_ctrl
// Directed and randomized checks of port_io_ctrl with FIFO_DEPTH=4 and
// HOLD_CYCLES=4. Expected values come from a queue model of the display
// stream and the status byte built from the flag rules.
module tb_port_io_ctrl;

  localparam int          DEPTH = 4;
  localparam logic [15:0] HOLD  = 16'd4;
  localparam logic [7:0]  P_OUT  = 8'h03;
  localparam logic [7:0]  P_IN   = 8'h01;
  localparam logic [7:0]  P_STAT = 8'h02;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] port_id = '0;
  logic       write_strobe = 1'b0;
  logic [7:0] out_data = '0;
  logic [7:0] in_data;
  logic [7:0] sw = '0;
  logic [7:0] disp_data;
  logic       disp_valid;
  logic       disp_ready = 1'b0;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] model_q [$];
  logic       model_ovf;

  always #5 clk = ~clk;

  port_io_ctrl #(
    .OUT_PORT    (P_OUT),
    .IN_PORT     (P_IN),
    .STAT_PORT   (P_STAT),
    .FIFO_DEPTH  (DEPTH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .out_data     (out_data),
    .in_data      (in_data),
    .sw           (sw),
    .disp_data    (disp_data),
    .disp_valid   (disp_valid),
    .disp_ready   (disp_ready),
    .overflow     (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input logic [7:0] pid, input logic we,
                               input logic [7:0] data, input logic rdy);
    port_id      = pid;
    write_strobe = we;
    out_data     = data;
    disp_ready   = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Status byte derived from the model: {overflow, full, empty, count}.
  function automatic logic [7:0] modelStatus(input logic ovf, input int n);
    return {ovf, logic'(n == DEPTH), logic'(n == 0), 5'(n)};
  endfunction

  task automatic waitValidRise(input string tag, input int budget, output logic got);
    logic prev;
    got  = 1'b0;
    prev = disp_valid;
    for (int i = 0; i < budget; i++) begin
      step();
      if (disp_valid && !prev) begin
        got = 1'b1;
        break;
      end
      prev = disp_valid;
    end
    checkOutput({tag, " rise"}, {7'b0, got}, 8'h01);
  endtask

  initial begin
    logic       got;
    int         r1, r2;
    logic [7:0] v, v0;

    // Reset state
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    repeat (3) step();
    checkOutput("reset in_data", in_data, 8'h00);
    checkOutput("reset disp_data", disp_data, 8'h00);
    checkOutput("reset disp_valid", {7'b0, disp_valid}, 8'h00);
    checkOutput("reset overflow", {7'b0, overflow}, 8'h00);
    rst_n = 1'b1;
    step();

    // Basic path: latency of the first value and dwell spacing
    applyStimulus(P_OUT, 1'b1, 8'h2A, 1'b1);
    step();
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
    checkOutput("latency +1 valid", {7'b0, disp_valid}, 8'h00);
    step();
    checkOutput("latency +2 valid", {7'b0, disp_valid}, 8'h01);
    checkOutput("latency +2 data", disp_data, 8'h2A);
    r1 = cyc;
    applyStimulus(P_OUT, 1'b1, 8'h15, 1'b1);
    step();
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
    checkOutput("accept drops valid", {7'b0, disp_valid}, 8'h00);
    checkOutput("data held after accept", disp_data, 8'h2A);
    waitValidRise("second value", 20, got);
    r2 = cyc;
    checkOutput("dwell spacing", 8'(r2 - r1), 8'(1 + int'(HOLD) + 1));
    checkOutput("second data", disp_data, 8'h15);
    repeat (10) step();

    // Backpressure and overflow: first value displayed, DEPTH queued, rest dropped
    model_q.delete();
    model_ovf = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(P_OUT, 1'b1, 8'(i), 1'b0);
      step();
      if (i > 1) begin
        if (model_q.size() < DEPTH) model_q.push_back(8'(i));
        else                        model_ovf = 1'b1;
      end
    end
    applyStimulus(P_STAT, 1'b0, 8'h00, 1'b0);
    step();
    step();
    checkOutput("bp disp_data", disp_data, 8'h01);
    checkOutput("bp disp_valid", {7'b0, disp_valid}, 8'h01);
    checkOutput("bp overflow", {7'b0, overflow}, {7'b0, model_ovf});
    checkOutput("bp status", in_data, modelStatus(model_ovf, model_q.size()));
    applyStimulus(P_STAT, 1'b1, 8'h80, 1'b0);
    step();
    applyStimulus(P_STAT, 1'b0, 8'h00, 1'b0);
    model_ovf = 1'b0;
    step();
    checkOutput("ovf clear flag", {7'b0, overflow}, 8'h00);
    checkOutput("ovf clear status", in_data, modelStatus(model_ovf, model_q.size()));

    // Full FIFO: push lands in the same cycle as the IDLE pop
    applyStimulus(P_STAT, 1'b0, 8'h00, 1'b1);
    step();
    applyStimulus(P_STAT, 1'b0, 8'h00, 1'b0);
    repeat (HOLD) step();
    applyStimulus(P_OUT, 1'b1, 8'hAA, 1'b0);
    step();
    applyStimulus(P_STAT, 1'b0, 8'h00, 1'b0);
    v = model_q.pop_front();
    model_q.push_back(8'hAA);
    checkOutput("full+pop valid", {7'b0, disp_valid}, 8'h01);
    checkOutput("full+pop data", disp_data, v);
    checkOutput("full+pop overflow", {7'b0, overflow}, 8'h00);
    step();
    checkOutput("full+pop status", in_data, modelStatus(1'b0, model_q.size()));
    applyStimulus(P_STAT, 1'b0, 8'h00, 1'b1);
    while (model_q.size() > 0) begin
      waitValidRise("drain", 40, got);
      v = model_q.pop_front();
      checkOutput("drain data", disp_data, v);
      if (!got) break;
    end
    checkOutput("drain overflow", {7'b0, overflow}, 8'h00);
    repeat (10) step();

    // Switch read through the synchronizer
    applyStimulus(P_IN, 1'b0, 8'h00, 1'b1);
    v0 = 8'($urandom_range(0, 255));
    if (v0 == 8'h5C) v0 = 8'hA3;
    sw = v0;
    repeat (4) step();
    checkOutput("sw initial", in_data, v0);
    sw = 8'h5C;
    step();
    step();
    checkOutput("sw not yet through", in_data, v0);
    step();
    checkOutput("sw 3rd cycle", in_data, 8'h5C);
    applyStimulus(8'h07, 1'b0, 8'h00, 1'b1);
    step();
    checkOutput("unmapped port read", in_data, 8'h00);
    for (int i = 0; i < 4; i++) begin
      v = 8'($urandom_range(0, 255));
      sw = v;
      applyStimulus(P_IN, 1'b0, 8'h00, 1'b1);
      repeat (3) step();
      checkOutput("sw random", in_data, v);
    end

    // Wrap-around: randomized stream spaced beyond the dwell
    model_q.delete();
    for (int i = 0; i < 10; i++) begin
      v = 8'($urandom_range(0, 255));
      model_q.push_back(v);
      applyStimulus(P_OUT, 1'b1, v, 1'b1);
      step();
      applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
      waitValidRise("wrap", 10, got);
      v = model_q.pop_front();
      checkOutput("wrap data", disp_data, v);
      repeat (int'(HOLD) + 4) step();
    end
    checkOutput("wrap overflow", {7'b0, overflow}, 8'h00);
    applyStimulus(P_STAT, 1'b0, 8'h00, 1'b1);
    step();
    step();
    checkOutput("wrap status", in_data, modelStatus(1'b0, 0));

    // Reset in PRESENT with three entries queued
    for (int i = 0; i < 4; i++) begin
      applyStimulus(P_OUT, 1'b1, 8'($urandom_range(1, 255)), 1'b0);
      step();
    end
    applyStimulus(P_STAT, 1'b0, 8'h00, 1'b0);
    step();
    checkOutput("pre-reset valid", {7'b0, disp_valid}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset in_data", in_data, 8'h00);
    checkOutput("async reset disp_data", disp_data, 8'h00);
    checkOutput("async reset disp_valid", {7'b0, disp_valid}, 8'h00);
    checkOutput("async reset overflow", {7'b0, overflow}, 8'h00);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    checkOutput("post-reset status", in_data, modelStatus(1'b0, 0));
    repeat (5) step();
    checkOutput("post-reset queue empty", {7'b0, disp_valid}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
